// File: rtl/l1a_tag_pkg.sv
// Shared constants and the tag word layout for the L1A tag FIFO.
package l1a_tag_pkg;

  localparam int BXN_W          = 12;
  localparam int L1A_CNT_W_DEF  = 24;
  localparam int TAG_W          = 1 + BXN_W + L1A_CNT_W_DEF;

  // Bit positions inside the tag word, LSB first.
  localparam int TAG_NUM_LSB    = 0;
  localparam int TAG_BXN_LSB    = TAG_NUM_LSB + L1A_CNT_W_DEF;
  localparam int TAG_MATCH_B    = TAG_BXN_LSB + BXN_W;

  // Last bunch crossing of an LHC orbit (3564 crossings, 0-based).
  localparam int LHC_BX_MAX     = 3563;

  // Tag word, MSB first: match flag, BXN, L1A number.
  typedef struct packed {
    logic                     match;
    logic [BXN_W-1:0]         bxn;
    logic [L1A_CNT_W_DEF-1:0] l1a_num;
  } l1a_tag_t;

endpackage : l1a_tag_pkg

// File: rtl/l1a_tag_ram.sv
// Tag storage: DEPTH x WIDTH simple dual-port RAM, synchronous write,
// asynchronous read, contents not reset (maps onto distributed RAM).
module l1a_tag_ram
  import l1a_tag_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = TAG_W
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: one tag per cycle at the write pointer.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : l1a_tag_ram

// File: rtl/l1a_tag_fifo.sv
// L1A tagger: runs the local BX counter and the L1A counter, tags each
// L1A with {match, BXN, L1A number} and buffers tags in a FWFT FIFO.
// Optional build macro DROP_CNT_EN adds an 8-bit saturating DROP_CNT port.
module l1a_tag_fifo
  import l1a_tag_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int L1A_CNT_W = L1A_CNT_W_DEF,
  parameter int BX_MAX    = LHC_BX_MAX,
  parameter int BX_OFFSET = 0
) (
  input  logic                       CLK40,
  input  logic                       RST_N,
  input  logic                       L1A,
  input  logic                       L1A_MATCH,
  input  logic                       RESYNC,
  input  logic                       BC0,
  input  logic                       RD_EN,
  output logic                       TAG_VALID,
  output logic [13+L1A_CNT_W-1:0]    TAG_DATA,
  output logic                       FIFO_FULL,
  output logic [$clog2(DEPTH):0]     WORDS,
  output logic                       OVF,
  output logic [BXN_W-1:0]           BXN,
  output logic [L1A_CNT_W-1:0]       L1A_CNT
`ifdef DROP_CNT_EN
  ,
  output logic [7:0]                 DROP_CNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = 1 + BXN_W + L1A_CNT_W;

  localparam logic [BXN_W-1:0] BX_MAX_L = BXN_W'(BX_MAX);
  localparam logic [BXN_W-1:0] BX_OFF_L = BXN_W'(BX_OFFSET);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [BXN_W-1:0]     bxn_q, bxn_d;
  logic [L1A_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic [PW-1:0]        words;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [L1A_CNT_W-1:0] cnt_inc;
  logic [TW-1:0]        tag_w;
  logic [TW-1:0]        ram_rdata;

  assign words   = wr_ptr_q - rd_ptr_q;
  assign empty   = (words == '0);
  assign full    = (words == PW'(DEPTH));
  assign cnt_inc = cnt_q + L1A_CNT_W'(1);

  // RESYNC overrides everything; a pop frees a slot for a same-cycle push.
  assign pop     = RD_EN & ~empty & ~RESYNC;
  assign push    = L1A & ~RESYNC & (~full | pop);
  assign drop    = L1A & ~RESYNC & full & ~pop;

  // Tag takes the BXN of the current cycle, before any BC0/RESYNC load.
  assign tag_w   = {L1A_MATCH, bxn_q, cnt_inc};

  // Next state for pointers, counters and the overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    bxn_d    = (bxn_q == BX_MAX_L) ? '0 : bxn_q + BXN_W'(1);
    if (RESYNC || BC0) begin
      bxn_d = BX_OFF_L;
    end
    if (RESYNC) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (L1A) begin
        cnt_d = cnt_inc;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      bxn_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      bxn_q    <= bxn_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  l1a_tag_ram #(
    .DEPTH (DEPTH),
    .WIDTH (TW)
  ) u_ram (
    .clk_i   (CLK40),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (tag_w),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign TAG_VALID = ~empty;
  // Masked so the output reads 0 while empty (RAM contents are never reset).
  assign TAG_DATA  = empty ? '0 : ram_rdata;
  assign FIFO_FULL = full;
  assign WORDS     = words;
  assign OVF       = ovf_q;
  assign BXN       = bxn_q;
  assign L1A_CNT   = cnt_q;

`ifdef DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Dropped-tag counter next state: cleared by RESYNC, saturates at 0xFF.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (RESYNC) begin
      drop_cnt_d = '0;
    end else if (drop) begin
      drop_cnt_d = sat_inc8(drop_cnt_q);
    end
  end

  // Dropped-tag counter register.
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`endif

  // Configuration sanity: offset inside the orbit, depth a power of two in 4..64.
  a_bx_offset_legal : assert property (@(posedge CLK40) disable iff (!RST_N)
    (BX_OFFSET >= 0) && (BX_OFFSET <= BX_MAX));
  a_depth_legal : assert property (@(posedge CLK40) disable iff (!RST_N)
    (DEPTH >= 4) && (DEPTH <= 64) && ((DEPTH & (DEPTH - 1)) == 0));

endmodule : l1a_tag_fifo
